// File: rtl/xbar_rtn_router.sv
// Return-path router below the shared cache: steers each sc return beat into a
// per-channel FIFO and presents it on that channel's mcash rtn valid/ready port.
module xbar_rtn_router #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sc_xbar_valid_i,
    output logic              sc_xbar_ready_o,
    input  logic [1:0]        sc_xbar_ch_id_i,
    input  logic [DATA_W-1:0] sc_xbar_data_i,
    output logic              mcash_ch0_rtn_valid_o,
    input  logic              mcash_ch0_rtn_ready_i,
    output logic [DATA_W-1:0] mcash_ch0_rtn_data_o,
    output logic              mcash_ch1_rtn_valid_o,
    input  logic              mcash_ch1_rtn_ready_i,
    output logic [DATA_W-1:0] mcash_ch1_rtn_data_o,
    output logic              mcash_ch2_rtn_valid_o,
    input  logic              mcash_ch2_rtn_ready_i,
    output logic [DATA_W-1:0] mcash_ch2_rtn_data_o,
    output logic              rtn_bad_ch_o
);

    localparam int NCH   = 3;
    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [NCH-1:0]    full_s;
    logic [NCH-1:0]    valid_s;
    logic [NCH-1:0]    push_s;
    logic [NCH-1:0]    pop_s;
    logic [NCH-1:0]    rtn_ready_s;
    logic [DATA_W-1:0] head_s [NCH];
    logic              ready_s;
    logic              bad_hit_s;
    logic              bad_r;

    assign rtn_ready_s = {mcash_ch2_rtn_ready_i, mcash_ch1_rtn_ready_i, mcash_ch0_rtn_ready_i};

    // Ready looks only at the addressed channel's current count; id 3 is always sunk.
    always_comb begin
        ready_s = 1'b1;
        case (sc_xbar_ch_id_i)
            2'd0:    ready_s = ~full_s[0];
            2'd1:    ready_s = ~full_s[1];
            2'd2:    ready_s = ~full_s[2];
            2'd3:    ready_s = 1'b1;
            default: ready_s = 1'b1;
        endcase
    end

    assign sc_xbar_ready_o = ready_s;
    assign bad_hit_s       = sc_xbar_valid_i & (sc_xbar_ch_id_i == 2'd3);

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            logic [DATA_W-1:0] mem_r [DEPTH];
            logic [PTR_W-1:0]  wptr_r;
            logic [PTR_W-1:0]  rptr_r;
            logic [CNT_W-1:0]  cnt_r;

            assign push_s[g]  = sc_xbar_valid_i & ready_s & (sc_xbar_ch_id_i == 2'(g));
            assign valid_s[g] = (cnt_r != {CNT_W{1'b0}});
            assign pop_s[g]   = valid_s[g] & rtn_ready_s[g];
            assign full_s[g]  = (cnt_r == FULL_CNT);
            assign head_s[g]  = valid_s[g] ? mem_r[rptr_r] : {DATA_W{1'b0}};

            // Pointer and occupancy state; pointers wrap naturally at DEPTH.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    wptr_r <= {PTR_W{1'b0}};
                    rptr_r <= {PTR_W{1'b0}};
                    cnt_r  <= {CNT_W{1'b0}};
                end else begin
                    if (push_s[g]) begin
                        wptr_r <= wptr_r + PTR_W'(1);
                    end else begin
                        wptr_r <= wptr_r;
                    end
                    if (pop_s[g]) begin
                        rptr_r <= rptr_r + PTR_W'(1);
                    end else begin
                        rptr_r <= rptr_r;
                    end
                    case ({push_s[g], pop_s[g]})
                        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                        default: cnt_r <= cnt_r;
                    endcase
                end
            end

            // Storage carries no reset; stale entries are masked by the count.
            always_ff @(posedge clk_i) begin
                if (push_s[g]) begin
                    mem_r[wptr_r] <= sc_xbar_data_i;
                end
            end
        end
    endgenerate

    // Sticky illegal-channel flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bad_r <= 1'b0;
        end else if (bad_hit_s) begin
            bad_r <= 1'b1;
        end else begin
            bad_r <= bad_r;
        end
    end

    assign rtn_bad_ch_o          = bad_r;
    assign mcash_ch0_rtn_valid_o = valid_s[0];
    assign mcash_ch1_rtn_valid_o = valid_s[1];
    assign mcash_ch2_rtn_valid_o = valid_s[2];
    assign mcash_ch0_rtn_data_o  = head_s[0];
    assign mcash_ch1_rtn_data_o  = head_s[1];
    assign mcash_ch2_rtn_data_o  = head_s[2];

endmodule

// File: doc/xbar_rtn_router.md
Name: xbar_rtn_router

Overview:
- Return-path stage directly downstream of the shared cache (sc) return port.
- Accepts one return beat per cycle from sc, tagged with a channel id.
- Buffers each beat in a per-channel FIFO and presents it on that channel's mcash rtn valid/ready port.
- Isolates channels: backpressure on one channel stalls only returns tagged for that channel.

Parameters:
- DEPTH, 4, entries per channel FIFO; power of two, >= 2.
- DATA_W, 128, return data width.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  asynchronous reset, active-low.
- sc_xbar_valid_i  input  1  sc return beat valid.
- sc_xbar_ready_o  output  1  beat accepted when valid and ready are both high.
- sc_xbar_ch_id_i  input  2  target channel, 0..2; 3 is illegal.
- sc_xbar_data_i  input  DATA_W  return data.
- mcash_ch0_rtn_valid_o  output  1  ch0 head valid.
- mcash_ch0_rtn_ready_i  input  1  ch0 consumer ready.
- mcash_ch0_rtn_data_o  output  DATA_W  ch0 head data.
- mcash_ch1_rtn_valid_o / mcash_ch1_rtn_ready_i / mcash_ch1_rtn_data_o: as ch0.
- mcash_ch2_rtn_valid_o / mcash_ch2_rtn_ready_i / mcash_ch2_rtn_data_o: as ch0.
- rtn_bad_ch_o  output  1  sticky flag: a beat with ch_id==3 was received.

Behaviour:
- Reset (rst_i low, asynchronous): all FIFO pointers and counts = 0; all rtn_valid_o = 0; rtn_bad_ch_o = 0. Storage is not reset.
- Reset mid-operation discards all buffered beats immediately.
- Each channel FIFO:
  - write pointer and read pointer of log2(DEPTH) bits, wrapping naturally at DEPTH;
  - count of log2(DEPTH)+1 bits, range 0..DEPTH.
- sc_xbar_ready_o is combinational on ch_id_i:
  - ch_id 0..2: high when count[ch_id] < DEPTH;
  - ch_id 3: always high (beat is sunk).
  - Ready may be high while valid is low; sc must not change ch_id/data while valid is high and ready is low.
- Push: on valid & ready with ch_id 0..2, write data at wptr[ch], wptr+1, count+1.
- Illegal id: on valid & ready with ch_id 3, write nothing and set rtn_bad_ch_o = 1 (held until reset).
- Channel outputs:
  - rtn_valid_o[ch] = (count[ch] != 0), registered-state derived;
  - rtn_data_o[ch] = mem[ch][rptr[ch]] when valid, else all-zero.
- Pop: on rtn_valid & rtn_ready, rptr+1, count-1.
- Latency: a beat accepted in cycle N is visible on the channel in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop on the same channel: count unchanged, both pointers advance.
- Full FIFO with a same-cycle pop: ready_o stays low, because ready is based on the current count. No pop-through.
- Empty FIFO with a same-cycle push: no pop is possible; valid rises next cycle.
- Ordering: per-channel FIFO order equals sc acceptance order. No ordering relation is defined across channels.
- Throughput: one push per cycle total; up to three pops per cycle (one per channel).
- rtn_ready_i is ignored when the channel is empty.

Test Plan:
- Basic routing.
  - Stimulus: after reset, send ch_id=1 with data=0xA5..A5, all rtn_ready=1.
  - Required: ch1 valid=1 with that data exactly one cycle later for one cycle; ch0 and ch2 valid stay 0; ready_o=1 throughout.
- Fill and backpressure.
  - Stimulus: ch2 rtn_ready=0; send 5 beats to ch2 with data 1..5.
  - Required: first 4 accepted; ready_o=0 on the 5th while ch_id=2.
  - Stimulus: then assert rtn_ready for one cycle.
  - Required: data 1 pops; 5th accepted the following cycle; drain order is 1,2,3,4,5.
- Channel isolation.
  - Stimulus: ch0 full and stalled; send beats to ch1.
  - Required: accepted back-to-back and delivered to ch1 at 1/cycle.
- Steady flow.
  - Stimulus: simultaneous push/pop on ch1 for 10 cycles with count=2.
  - Required: count stays 2 and pointers wrap past DEPTH without loss; 10 beats out in order.
- Illegal id.
  - Stimulus: send ch_id=3.
  - Required: ready_o=1; no channel valid rises; rtn_bad_ch_o=1 next cycle and it stays 1.
- Reset mid-traffic.
  - Stimulus: drive rst_i low with 3 beats buffered in ch0.
  - Required: ch0 valid=0 asynchronously; after release, FIFO empty and bad flag 0.
